multicycle_ctrl_fsm: RTL

- Control unit for the Multi-Cycle ARM core, successor to the single-cycle decoder.
- A registered main FSM sequences each instruction through Fetch/Decode/Execute/Memory/Writeback and drives datapath mux selects and write enables for every cycle.
- Integrates an extended ALU decoder (optional EOR/CMN/TST/MOV), a memory-ready handshake for wait-stated memory, and illegal-instruction detection.
- The condition-check unit sits downstream and gates RegW, MemW, PCS and NextPC by Cond.

---
 rtl/multicycle_ctrl_fsm.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle ARM control unit: registered main FSM plus combinational datapath
// control, extended ALU decode, memory-ready handshake and illegal-op detection.
module multicycle_ctrl_fsm #(
  parameter bit EXT_OPS = 1'b1,
  parameter bit MEM_HS  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       mem_ready,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       PCS,
  output logic [2:0] ALUCtrl,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t state_q, state_d;

  logic       hs_ok;
  logic [2:0] dec_alu;
  logic [1:0] dec_flag;
  logic       dec_nowrite;
  logic       dp_legal;

  logic       next_pc_c, ir_write_c, reg_w_c, mem_w_c, branch_c;

  assign hs_ok = MEM_HS ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // ALU decode keyed on cmd = Funct[4:1], S = Funct[0]; also flags undefined DP cmds
  always_comb begin
    dec_alu     = 3'b000;
    dec_flag    = 2'b00;
    dec_nowrite = 1'b0;
    dp_legal    = 1'b1;
    case (Funct[4:1])
      4'b0100: begin dec_alu = 3'b000; dec_flag = Funct[0] ? 2'b11 : 2'b00; end
      4'b0010: begin dec_alu = 3'b001; dec_flag = Funct[0] ? 2'b11 : 2'b00; end
      4'b0000: begin dec_alu = 3'b010; dec_flag = Funct[0] ? 2'b10 : 2'b00; end
      4'b1100: begin dec_alu = 3'b011; dec_flag = Funct[0] ? 2'b10 : 2'b00; end
      4'b1010: begin dec_alu = 3'b001; dec_flag = 2'b11; dec_nowrite = 1'b1; end
      4'b0001: begin
        if (EXT_OPS) begin dec_alu = 3'b100; dec_flag = Funct[0] ? 2'b10 : 2'b00; end
        else dp_legal = 1'b0;
      end
      4'b1011: begin
        if (EXT_OPS) begin dec_alu = 3'b000; dec_flag = 2'b11; dec_nowrite = 1'b1; end
        else dp_legal = 1'b0;
      end
      4'b1000: begin
        if (EXT_OPS) begin dec_alu = 3'b010; dec_flag = 2'b10; dec_nowrite = 1'b1; end
        else dp_legal = 1'b0;
      end
      4'b1101: begin
        if (EXT_OPS) begin dec_alu = 3'b101; dec_flag = Funct[0] ? 2'b10 : 2'b00; end
        else dp_legal = 1'b0;
      end
      default: dp_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = S_FETCH;
    next_pc_c  = 1'b0;
    ir_write_c = 1'b0;
    reg_w_c    = 1'b0;
    mem_w_c    = 1'b0;
    branch_c   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUCtrl    = 3'b000;
    FlagW      = 2'b00;
    NoWrite    = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        next_pc_c  = hs_ok;
        ir_write_c = hs_ok;
        state_d    = hs_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ImmSrc    = (Op == 2'b01) ? 2'b01 : ((Op == 2'b10) ? 2'b10 : 2'b00);
        RegSrc    = {Op == 2'b01, Op == 2'b10};
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          2'b00: begin
            if (dp_legal) state_d = Funct[5] ? S_EXECI : S_EXECR;
            else begin state_d = S_FETCH; illegal = 1'b1; end
          end
          default: begin state_d = S_FETCH; illegal = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = hs_ok ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_c   = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        RegSrc  = 2'b10;
        mem_w_c = 1'b1;
        state_d = hs_ok ? S_FETCH : S_MEMWR;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUCtrl = dec_alu;
        FlagW   = dec_flag;
        NoWrite = dec_nowrite;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ALUCtrl = dec_alu;
        FlagW   = dec_flag;
        NoWrite = dec_nowrite;
        reg_w_c = ~dec_nowrite;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        RegSrc    = 2'b01;
        ResultSrc = 2'b10;
        branch_c  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // A reset cycle aborts the instruction, so no architectural write may escape
  assign NextPC  = next_pc_c  & ~reset;
  assign IRWrite = ir_write_c & ~reset;
  assign RegW    = reg_w_c    & ~reset;
  assign MemW    = mem_w_c    & ~reset;
  assign Branch  = branch_c   & ~reset;
  assign PCS     = ((Rd == 4'hF) & RegW) | Branch;
  assign state   = state_q;

endmodule
